// File: rtl/acq_frame_sched.sv
// Acquisition scheduler: turns start/stop pulses and the acquisition mode
// into the acquisition level for stream_ctrl, ending bursts on frame edges.
module acq_frame_sched #(
    parameter int FRAME_CNT_WD = 16
) (
    input  logic                    clk_pix,
    input  logic                    reset_pix_n,
    input  logic                    i_fval,
    input  logic                    i_stream_enable,
    input  logic                    i_acq_start,
    input  logic                    i_acq_stop,
    input  logic [1:0]              iv_acq_mode,
    input  logic [FRAME_CNT_WD-1:0] iv_frame_burst,
    output logic                    o_acquisition_start,
    output logic                    o_acq_busy,
    output logic                    o_acq_done,
    output logic                    o_acq_abort,
    output logic [FRAME_CNT_WD-1:0] ov_frame_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [1:0] MODE_SINGLE = 2'd1;
    localparam logic [1:0] MODE_MULTI  = 2'd2;

    state_t                  r_state;
    state_t                  w_nxt;
    logic                    r_fval_d;
    logic [1:0]              r_mode;
    logic [FRAME_CNT_WD-1:0] r_burst;
    logic [FRAME_CNT_WD-1:0] r_frame_cnt;
    logic                    r_acq_start;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_abort;

    logic                    w_rise;
    logic                    w_fall;
    logic                    w_accept;
    logic                    w_abort;
    logic                    w_cnt_inc;
    logic                    w_burst_hit;
    logic [FRAME_CNT_WD:0]   w_cnt_p1;

    assign w_rise      = i_fval & ~r_fval_d;
    assign w_fall      = ~i_fval & r_fval_d;
    assign w_cnt_p1    = {1'b0, r_frame_cnt} + {{FRAME_CNT_WD{1'b0}}, 1'b1};
    assign w_burst_hit = (r_mode == MODE_MULTI) && (w_cnt_p1 == {1'b0, r_burst});

    always_comb begin
        w_nxt     = r_state;
        w_accept  = 1'b0;
        w_abort   = 1'b0;
        w_cnt_inc = 1'b0;
        if (r_state != S_IDLE && !i_stream_enable) begin
            w_nxt   = S_IDLE;
            w_abort = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_acq_start && i_stream_enable && !i_acq_stop) begin
                        w_accept = 1'b1;
                        w_nxt    = S_ARM;
                    end
                end
                S_ARM: begin
                    if (i_acq_stop)
                        w_nxt = S_IDLE;
                    else if (w_rise)
                        w_nxt = S_RUN;
                end
                S_RUN: begin
                    if (w_fall) begin
                        w_cnt_inc = 1'b1;
                        if (i_acq_stop || r_mode == MODE_SINGLE || w_burst_hit)
                            w_nxt = S_DONE;
                    end else if (i_acq_stop) begin
                        w_nxt = i_fval ? S_DRAIN : S_DONE;
                    end
                end
                S_DRAIN: begin
                    if (w_fall) begin
                        w_cnt_inc = 1'b1;
                        w_nxt     = S_DONE;
                    end
                end
                S_DONE:  w_nxt = S_IDLE;
                default: w_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_pix or negedge reset_pix_n) begin
        if (!reset_pix_n) begin
            r_state     <= S_IDLE;
            r_fval_d    <= 1'b0;
            r_mode      <= 2'd0;
            r_burst     <= '0;
            r_frame_cnt <= '0;
            r_acq_start <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_state     <= w_nxt;
            r_fval_d    <= i_fval;
            // Outputs are decoded from the next state so they align with it
            r_acq_start <= (w_nxt == S_ARM) || (w_nxt == S_RUN);
            r_busy      <= (w_nxt != S_IDLE);
            r_done      <= (w_nxt == S_DONE);
            r_abort     <= w_abort;
            if (w_accept) begin
                r_mode      <= iv_acq_mode;
                r_frame_cnt <= '0;
                if (iv_acq_mode == MODE_MULTI && iv_frame_burst == '0)
                    r_burst <= {{(FRAME_CNT_WD-1){1'b0}}, 1'b1};
                else
                    r_burst <= iv_frame_burst;
            end else if (w_cnt_inc && !(&r_frame_cnt)) begin
                r_frame_cnt <= w_cnt_p1[FRAME_CNT_WD-1:0];
            end
        end
    end

    assign o_acquisition_start = r_acq_start;
    assign o_acq_busy          = r_busy;
    assign o_acq_done          = r_done;
    assign o_acq_abort         = r_abort;
    assign ov_frame_cnt        = r_frame_cnt;

endmodule

// File: tb/tb_acq_frame_sched.sv
// Directed bench for acq_frame_sched: modes, stop/drain, abort, reset.
module tb_acq_frame_sched;

    logic        clk_pix = 1'b0;
    logic        reset_pix_n;
    logic        i_fval;
    logic        i_stream_enable;
    logic        i_acq_start;
    logic        i_acq_stop;
    logic [1:0]  iv_acq_mode;
    logic [15:0] iv_frame_burst;
    logic        o_acquisition_start;
    logic        o_acq_busy;
    logic        o_acq_done;
    logic        o_acq_abort;
    logic [15:0] ov_frame_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    int n_done = 0;
    int n_abort = 0;

    acq_frame_sched #(.FRAME_CNT_WD(16)) dut (
        .clk_pix             (clk_pix),
        .reset_pix_n         (reset_pix_n),
        .i_fval              (i_fval),
        .i_stream_enable     (i_stream_enable),
        .i_acq_start         (i_acq_start),
        .i_acq_stop          (i_acq_stop),
        .iv_acq_mode         (iv_acq_mode),
        .iv_frame_burst      (iv_frame_burst),
        .o_acquisition_start (o_acquisition_start),
        .o_acq_busy          (o_acq_busy),
        .o_acq_done          (o_acq_done),
        .o_acq_abort         (o_acq_abort),
        .ov_frame_cnt        (ov_frame_cnt)
    );

    always #5 clk_pix = ~clk_pix;

    always @(negedge clk_pix) begin
        if (o_acq_done)  n_done++;
        if (o_acq_abort) n_abort++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_pix);
        #1;
    endtask

    task automatic pulse_start();
        i_acq_start = 1'b1;
        tick();
        i_acq_start = 1'b0;
    endtask

    task automatic frame(input int hi, input int lo);
        i_fval = 1'b1;
        repeat (hi) tick();
        i_fval = 1'b0;
        repeat (lo) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_pix_n = 1'b0;
        i_fval = 1'b0;
        i_stream_enable = 1'b1;
        i_acq_start = 1'b0;
        i_acq_stop = 1'b0;
        iv_acq_mode = 2'd0;
        iv_frame_burst = 16'd0;
        repeat (3) tick();
        chk("rst_acq",   o_acquisition_start, 0);
        chk("rst_busy",  o_acq_busy, 0);
        chk("rst_done",  o_acq_done, 0);
        chk("rst_abort", o_acq_abort, 0);
        chk("rst_cnt",   ov_frame_cnt, 0);
        reset_pix_n = 1'b1;
        repeat (2) tick();

        // single mode; mode change after start must be ignored
        n_done = 0;
        iv_acq_mode = 2'd1;
        pulse_start();
        chk("t1_acq_lat",  o_acquisition_start, 1);
        chk("t1_busy_lat", o_acq_busy, 1);
        iv_acq_mode = 2'd0;
        i_fval = 1'b1;
        tick();
        chk("t1_acq_run", o_acquisition_start, 1);
        repeat (3) tick();
        i_fval = 1'b0;
        tick();
        chk("t1_acq_off", o_acquisition_start, 0);
        chk("t1_done",    o_acq_done, 1);
        chk("t1_cnt",     ov_frame_cnt, 1);
        tick();
        chk("t1_done_1cy", o_acq_done, 0);
        chk("t1_idle",     o_acq_busy, 0);
        tick();
        frame(4, 3);
        chk("t1_cnt_hold", ov_frame_cnt, 1);
        chk("t1_ndone",    n_done, 1);

        // multi mode, burst 3, five frames
        n_done = 0;
        iv_acq_mode = 2'd2;
        iv_frame_burst = 16'd3;
        pulse_start();
        chk("t2_cnt_clr", ov_frame_cnt, 0);
        frame(4, 3);
        frame(4, 3);
        chk("t2_cnt2", ov_frame_cnt, 2);
        chk("t2_acq2", o_acquisition_start, 1);
        i_fval = 1'b1;
        repeat (4) tick();
        i_fval = 1'b0;
        tick();
        chk("t2_acq_off", o_acquisition_start, 0);
        chk("t2_done",    o_acq_done, 1);
        chk("t2_cnt3",    ov_frame_cnt, 3);
        tick();
        frame(4, 3);
        frame(4, 3);
        chk("t2_cnt_end", ov_frame_cnt, 3);
        chk("t2_ndone",   n_done, 1);

        // continuous, stop mid-frame 4 -> drain
        n_done = 0;
        iv_acq_mode = 2'd0;
        pulse_start();
        repeat (3) frame(4, 3);
        i_fval = 1'b1;
        repeat (2) tick();
        i_acq_stop = 1'b1;
        tick();
        i_acq_stop = 1'b0;
        chk("t3_drain_acq",  o_acquisition_start, 0);
        chk("t3_drain_busy", o_acq_busy, 1);
        chk("t3_drain_cnt",  ov_frame_cnt, 3);
        repeat (2) tick();
        i_fval = 1'b0;
        tick();
        chk("t3_done", o_acq_done, 1);
        chk("t3_cnt",  ov_frame_cnt, 4);
        tick();
        chk("t3_ndone", n_done, 1);

        // multi mode, burst 0 acts as 1
        n_done = 0;
        iv_acq_mode = 2'd2;
        iv_frame_burst = 16'd0;
        pulse_start();
        frame(4, 3);
        frame(4, 3);
        chk("t4_cnt",   ov_frame_cnt, 1);
        chk("t4_ndone", n_done, 1);
        chk("t4_busy",  o_acq_busy, 0);

        // stream disable during frame 2
        n_done = 0;
        n_abort = 0;
        iv_acq_mode = 2'd0;
        pulse_start();
        frame(4, 3);
        i_fval = 1'b1;
        repeat (2) tick();
        i_stream_enable = 1'b0;
        tick();
        chk("t5_abort", o_acq_abort, 1);
        chk("t5_acq",   o_acquisition_start, 0);
        chk("t5_busy",  o_acq_busy, 0);
        chk("t5_cnt",   ov_frame_cnt, 1);
        i_stream_enable = 1'b1;
        tick();
        chk("t5_abort_1cy", o_acq_abort, 0);
        i_fval = 1'b0;
        repeat (3) tick();
        chk("t5_ndone",  n_done, 0);
        chk("t5_nabort", n_abort, 1);

        // start+stop same cycle, then async reset mid-RUN
        iv_acq_mode = 2'd1;
        i_acq_start = 1'b1;
        i_acq_stop = 1'b1;
        tick();
        i_acq_start = 1'b0;
        i_acq_stop = 1'b0;
        chk("t6_nostart_busy", o_acq_busy, 0);
        chk("t6_nostart_acq",  o_acquisition_start, 0);
        iv_acq_mode = 2'd0;
        pulse_start();
        frame(4, 3);
        i_fval = 1'b1;
        repeat (2) tick();
        chk("t6_run_cnt", ov_frame_cnt, 1);
        chk("t6_run_acq", o_acquisition_start, 1);
        #2 reset_pix_n = 1'b0;
        #1;
        chk("t6_rst_acq",  o_acquisition_start, 0);
        chk("t6_rst_busy", o_acq_busy, 0);
        chk("t6_rst_cnt",  ov_frame_cnt, 0);
        i_fval = 1'b0;
        repeat (2) tick();
        reset_pix_n = 1'b1;
        tick();
        n_done = 0;
        iv_acq_mode = 2'd1;
        pulse_start();
        chk("t6_restart_busy", o_acq_busy, 1);
        frame(4, 3);
        chk("t6_restart_cnt",  ov_frame_cnt, 1);
        chk("t6_restart_done", n_done, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
